z80_bus_initiator: RTL
======================

Name: z80_bus_initiator

Overview:
- Host-side Z80 bus master. It turns single-beat read/write requests into Z80-style memory or I/O cycles on a Z80MasterBus port.
- It acquires the bus through the BUSRQ/BUSACK arbitration used by the CPU/DMA master mux, and honours slave wait (mwait).
- It returns read data and completion status on a response handshake.
- It sits beside the DMA master as a third initiator. Typical use is a UART debug monitor peeking and poking ROM, RAM, VRAM and I/O.

Parameters:
- HOLD_BUS, 0: when 1, keep busrq asserted between back-to-back requests (req_valid already high in RESP); when 0, release after every transaction.
- TIMEOUT_CYCLES, 255: maximum number of TW states before abort. Used only with BUS_TIMEOUT_EN; range 1..255, 8-bit counter.

Ports:
- masterclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  T-state strobe, one masterclk wide, CPU clock rising edge
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1=write, 0=read
- req_io  in  1  1=I/O cycle (iorqn), 0=memory cycle (mreqn)
- req_addr  in  16  bus address
- req_wdata  in  8  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  8  read data (00h for writes)
- rsp_err  out  1  timeout abort flag
- busrq  out  1  active-high bus request to CPU arbitration
- busack  in  1  active-high grant
- m_obus  out  Z80MasterBus  addr/dmaster/rdn/wrn/mreqn/iorqn driven by this block
- m_ibus  in  Z80SlaveBus  shared slave return: dslave, mwait (active-low wait)

Behaviour:
- Reset, asynchronous on rst_n low, any state: state=IDLE, busrq=0, req_ready=0, rsp_valid=0, rsp_rdata=00h, rsp_err=0, addr=0000h, dmaster=00h, rdn=wrn=mreqn=iorqn=1.
- A reset mid-cycle drops all strobes immediately; no partial response is issued.
- State machine:
  - IDLE: req_ready=1. On req_valid: latch we/io/addr/wdata, req_ready→0, busrq→1, go to GRANT.
  - GRANT: wait busack=1, sampled on masterclk, no cen needed. Then wait for the next cen and enter T1.
  - T1 (one cen period): addr driven. For reads, mreqn or iorqn=0 and rdn=0 from T1 entry. For writes, mreqn/iorqn=0 and dmaster=wdata from T1 entry.
  - T2: for writes, wrn=0 from T2 entry. At the cen ending T2, sample mwait: if 0 go to TW, else go to T3.
  - TW: strobes held. Each cen re-samples mwait; go to T3 when mwait=1.
  - T3: for reads, rsp_rdata latches m_ibus.dslave on the cen that enters T3. On the cen that ends T3: deassert all strobes, addr/dmaster held, go to RESP.
  - RESP: rsp_valid=1. On rsp_ready: rsp_valid→0. Then:
    - HOLD_BUS=1 and req_valid=1: go to IDLE with busrq kept high. Re-entry to GRANT passes straight through because busack is still 1.
    - Otherwise: busrq→0, go to IDLE.
- Strobes never assert outside T1..T3. rdn and wrn are never low together.
- busack falls while in T1..T3/TW: treat as a protocol error. Strobes deassert, rsp_err=1, go to RESP.
- req_valid during non-IDLE states is ignored (req_ready=0). There is no request queueing.
- Latency with no wait states is GRANT + 3 cen periods + 1 masterclk to rsp_valid.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: an 8-bit counter clears on T2 entry and increments per TW cen. At count==TIMEOUT_CYCLES the cycle is forced to end: strobes deassert, rsp_rdata=FFh, rsp_err=1, go to RESP.
- Undefined: TW lasts indefinitely. rsp_err is driven only by the busack-loss error.

Test Plan:
- Read, no wait: busack returns after 2 clks; mem read 3F00h with dslave=A5h, mwait=1. Required: rdn/mreqn low for exactly 3 cen periods, rsp_rdata=A5h, rsp_err=0, busrq drops after rsp_ready.
- Write to VRAM with wait: write 7400h←5Ah, mwait=0 for 4 cen. Required: wrn low from T2, 4 TW states, dmaster=5Ah throughout, one response with rsp_rdata=00h.
- I/O write: req_io=1, addr 7D84h←01h. Required: iorqn low and mreqn high for the whole cycle.
- Back-to-back with HOLD_BUS=1: two reads queued. Required: busrq stays 1 between transactions, second T1 has no GRANT wait.
- Reset mid-TW: rst_n low during TW. Required: all strobes 1, busrq=0 and rsp_valid=0 asynchronously.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and mwait stuck 0. Required: abort after 4 TW states, rsp_err=1, rsp_rdata=FFh.

Source files
------------

// File: rtl/z80_bus_initiator.sv
// Host-side Z80 bus master: turns single-beat requests into Z80 memory/I-O cycles after BUSRQ/BUSACK.
// Optional macro BUS_TIMEOUT_EN aborts a cycle after TIMEOUT_CYCLES wait states.
package z80_bus_pkg;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dmaster;
    logic        rdn;
    logic        wrn;
    logic        mreqn;
    logic        iorqn;
  } Z80MasterBus;

  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;
endpackage

module z80_bus_initiator
  import z80_bus_pkg::*;
#(
  parameter bit          HOLD_BUS       = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        masterclk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_io,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busrq,
  input  logic        busack,
  output Z80MasterBus m_obus,
  input  Z80SlaveBus  m_ibus
);

  typedef enum logic [2:0] {
    IDLE, GRANT, SYNC, T1, T2, TW, T3, RESP
  } state_e;

  localparam Z80MasterBus BusIdle = '{addr: 16'h0000, dmaster: 8'h00,
                                      rdn: 1'b1, wrn: 1'b1, mreqn: 1'b1, iorqn: 1'b1};

  state_e      state_q, state_d;
  logic        busrq_q, busrq_d;
  logic        reqReady_q, reqReady_d;
  logic        rspValid_q, rspValid_d;
  logic [7:0]  rspRdata_q, rspRdata_d;
  logic        rspErr_q, rspErr_d;
  logic        we_q, we_d;
  logic        io_q, io_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  Z80MasterBus bus_q, bus_d;
  logic        busLost;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
  logic [7:0] twCnt_q, twCnt_d;
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
`endif

  // Address and data stay on the bus after a cycle; only the strobes are released.
  function automatic Z80MasterBus releaseStrobes(input Z80MasterBus b);
    Z80MasterBus r;
    r       = b;
    r.rdn   = 1'b1;
    r.wrn   = 1'b1;
    r.mreqn = 1'b1;
    r.iorqn = 1'b1;
    return r;
  endfunction

  assign busLost = !busack && (state_q == T1 || state_q == T2 ||
                               state_q == TW || state_q == T3);

  always_comb begin
    state_d    = state_q;
    busrq_d    = busrq_q;
    rspValid_d = rspValid_q;
    rspRdata_d = rspRdata_q;
    rspErr_d   = rspErr_q;
    we_d       = we_q;
    io_d       = io_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bus_d      = bus_q;
`ifdef BUS_TIMEOUT_EN
    twCnt_d    = twCnt_q;
`endif

    if (busLost) begin
      bus_d      = releaseStrobes(bus_q);
      rspErr_d   = 1'b1;
      rspValid_d = 1'b1;
      state_d    = RESP;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && reqReady_q) begin
            we_d       = req_we;
            io_d       = req_io;
            addr_d     = req_addr;
            wdata_d    = req_wdata;
            rspRdata_d = 8'h00;
            rspErr_d   = 1'b0;
            busrq_d    = 1'b1;
            state_d    = GRANT;
          end else if (!req_valid) begin
            busrq_d = 1'b0;
          end
        end
        GRANT: begin
          if (busack) state_d = SYNC;
        end
        SYNC: begin
          if (cen) begin
            bus_d.addr  = addr_q;
            bus_d.mreqn = io_q;
            bus_d.iorqn = !io_q;
            bus_d.rdn   = we_q;
            if (we_q) bus_d.dmaster = wdata_q;
            state_d = T1;
          end
        end
        T1: begin
          if (cen) begin
            if (we_q) bus_d.wrn = 1'b0;
`ifdef BUS_TIMEOUT_EN
            twCnt_d = 8'd0;
`endif
            state_d = T2;
          end
        end
        T2: begin
          if (cen) begin
            if (m_ibus.mwait) begin
              if (!we_q) rspRdata_d = m_ibus.dslave;
              state_d = T3;
            end else begin
              state_d = TW;
            end
          end
        end
        TW: begin
          if (cen) begin
            if (m_ibus.mwait) begin
              if (!we_q) rspRdata_d = m_ibus.dslave;
              state_d = T3;
            end
`ifdef BUS_TIMEOUT_EN
            else begin
              twCnt_d = twCnt_q + 8'd1;
              if (twCnt_d == TimeoutLimit) begin
                bus_d      = releaseStrobes(bus_q);
                rspRdata_d = 8'hFF;
                rspErr_d   = 1'b1;
                rspValid_d = 1'b1;
                state_d    = RESP;
              end
            end
`endif
          end
        end
        T3: begin
          if (cen) begin
            bus_d      = releaseStrobes(bus_q);
            rspValid_d = 1'b1;
            state_d    = RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_d = 1'b0;
            // Holding keeps busack high so the next GRANT falls straight through.
            if (!(HOLD_BUS && req_valid)) busrq_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    reqReady_d = (state_d == IDLE);
  end

  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busrq_q    <= 1'b0;
      reqReady_q <= 1'b0;
      rspValid_q <= 1'b0;
      rspRdata_q <= 8'h00;
      rspErr_q   <= 1'b0;
      we_q       <= 1'b0;
      io_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      bus_q      <= BusIdle;
`ifdef BUS_TIMEOUT_EN
      twCnt_q    <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      busrq_q    <= busrq_d;
      reqReady_q <= reqReady_d;
      rspValid_q <= rspValid_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
      we_q       <= we_d;
      io_q       <= io_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bus_q      <= bus_d;
`ifdef BUS_TIMEOUT_EN
      twCnt_q    <= twCnt_d;
`endif
    end
  end

  assign req_ready = reqReady_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;
  assign busrq     = busrq_q;
  assign m_obus    = bus_q;

endmodule
